lfsr_prbs_checker: RTL and testbench

Serial PRBS checker for the 8-bit Galois LFSR generator. It consumes the generator's serial output, one bit per cycle, taken from stage Y[8] after each shift. It self-synchronises to the stream, declares lock, then counts bit mismatches. It sits at the receive end of a link or loopback test path, opposite the generator.

---
 rtl/lfsr_prbs_checker_pkg.sv | 17 +
 rtl/prbs_predict.sv | 20 ++
 rtl/lfsr_prbs_checker.sv | 155 +++++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_prbs_checker_pkg.sv
// Shared constants for the 8-bit Galois LFSR PRBS generator/checker pair.
// State encoding is visible on the debug port, so it is fixed here.
package lfsr_prbs_checker_pkg;

  localparam int LFSR_LEN = 8;
  localparam int CNT_W    = 16;

  localparam logic [8:1] TAPS_DEFAULT = 8'b1010_0101;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CHECK   = 2'd1,
    LOCKED  = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/prbs_predict.sv
// Combinational next-bit prediction from the received-bit history.
// The top history stage always feeds back; taps 1..length-1 are selectable.
module prbs_predict
  import lfsr_prbs_checker_pkg::*;
#(
  parameter int                length          = LFSR_LEN,
  parameter logic [length:1]   Tap_Coefficient = TAPS_DEFAULT
) (
  input  logic [length:1] hist_i,
  output logic            pred_o
);

  logic [length-1:1] tapped;

  assign tapped = hist_i[length-1:1]
                & Tap_Coefficient[length-1:1];

  assign pred_o = hist_i[length] ^ (^tapped);

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising serial PRBS checker: hunts, locks, then counts
// bit mismatches against the LFSR recurrence of the received stream.
module lfsr_prbs_checker
  import lfsr_prbs_checker_pkg::*;
#(
  parameter int              length          = LFSR_LEN,
  parameter logic [length:1] Tap_Coefficient = TAPS_DEFAULT,
  parameter int              SYNC_COUNT      = 16,
  parameter int              LOSS_COUNT      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam logic [3:0] FILL_LAST = 4'(length - 1);
  localparam logic [7:0] SYNC_N    = 8'(SYNC_COUNT);
  localparam logic [7:0] LOSS_N    = 8'(LOSS_COUNT);

  state_e            state_q, state_d;
  logic [length:1]   h_q, h_d;
  logic [3:0]        fill_q, fill_d;
  logic [7:0]        good_q, good_d;
  logic [7:0]        miss_q, miss_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              lock_q, lock_d;

  logic              pred;
  logic              miss_bit;
  logic              zero;
  logic              count_ev;
  logic [length:1]   h_shift;

  prbs_predict #(
    .length          (length),
    .Tap_Coefficient (Tap_Coefficient)
  ) u_pred (
    .hist_i (h_q),
    .pred_o (pred)
  );

  // The received bit, not the prediction, enters the history.
  assign h_shift  = {h_q[length-1:1], din};
  assign zero     = (h_shift == '0);
  assign miss_bit = din ^ pred;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      h_q     <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    good_d  = good_q;
    miss_d  = miss_q;
    if (state_q == ILLEGAL) begin
      state_d = HUNT;
      fill_d  = '0;
      good_d  = '0;
      miss_d  = '0;
    end else if (din_valid) begin
      h_d = h_shift;
      // An all-zero history is the LFSR lock-up state: restart the hunt.
      if (zero) begin
        state_d = HUNT;
        fill_d  = '0;
        good_d  = '0;
        miss_d  = '0;
      end else begin
        unique case (state_q)
          HUNT: begin
            if (fill_q == FILL_LAST) begin
              state_d = CHECK;
              fill_d  = '0;
              good_d  = '0;
            end else begin
              fill_d = fill_q + 4'd1;
            end
          end
          CHECK: begin
            if (miss_bit) begin
              good_d = '0;
            end else if (good_q + 8'd1 == SYNC_N) begin
              state_d = LOCKED;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              good_d = good_q + 8'd1;
            end
          end
          LOCKED: begin
            if (!miss_bit) begin
              miss_d = '0;
            end else if (miss_q + 8'd1 == LOSS_N) begin
              state_d = HUNT;
              fill_d  = '0;
              miss_d  = '0;
              h_d     = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  assign count_ev = din_valid && !zero
                 && (state_q == LOCKED) && miss_bit;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = count_ev;
    if (count_ev && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr) begin
      cnt_d = '0;
    end
    lock_d = (state_d == LOCKED);
  end

  assign locked    = lock_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: lock, errors, loss, gaps,
// clear, saturation and asynchronous reset.
module tb_lfsr_prbs_checker;
  import lfsr_prbs_checker_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clr;
  logic        din;
  logic        din_valid;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  logic [8:1] gen;
  logic [8:0] eh;
  logic [8:1] rxh;

  lfsr_prbs_checker dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state     (state)
  );

  always #5 clock = ~clock;

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chkb(input string tag,
                      input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Default-tap recurrence: s_t = s_t-8 ^ s_t-6 ^ s_t-3 ^ s_t-1
  function automatic logic gen_next(input logic [8:1] g);
    return g[8] ^ g[6] ^ g[3] ^ g[1];
  endfunction

  // True when inverting the next nflip bits never leaves a zero window.
  function automatic logic cand_ok(input logic [8:1] g,
                                   input logic [8:1] h,
                                   input int nflip);
    logic [8:1] x;
    logic [8:1] y;
    logic       b;
    x = g;
    y = h;
    for (int i = 0; i < nflip + 8; i++) begin
      b = gen_next(x);
      x = {x[7:1], b};
      y = {y[7:1], b ^ (i < nflip)};
      if (y == '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic b, input logic v,
                      input logic c);
    @(negedge clock);
    din       = b;
    din_valid = v;
    clr       = c;
    @(posedge clock);
    #1;
    if (v) rxh = {rxh[7:1], b};
  endtask

  // Line error e propagates to mismatches at offsets 0,1,3,6,8.
  task automatic send_gen(input logic e, input logic c,
                          output logic miss_exp);
    logic s;
    s   = gen_next(gen);
    gen = {gen[7:1], s};
    eh  = {eh[7:0], e};
    miss_exp = eh[0] ^ eh[1] ^ eh[3] ^ eh[6] ^ eh[8];
    step(s ^ e, 1'b1, c);
  endtask

  task automatic do_reset();
    din       = 1'b0;
    din_valid = 1'b0;
    clr       = 1'b0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    gen = 8'b0000_0001;
    eh  = '0;
    rxh = '0;
  endtask

  initial begin
    logic mx;
    logic p;
    logic m;
    int   cnt;
    int   run;
    int   n;
    int   lz;
    int   nvalid;
    int   guard;
    logic [8:1] x;

    do_reset();
    chkb("rst_locked", locked, 1'b0);
    chkb("rst_pulse", err_pulse, 1'b0);
    chkw("rst_count", err_count, 16'h0000);
    chkw("rst_state", {14'b0, state}, 16'(HUNT));

    // Clean lock at valid bit 24
    for (int i = 1; i <= 23; i++) send_gen(1'b0, 1'b0, mx);
    chkb("lock_bit23", locked, 1'b0);
    chkw("state_bit23", {14'b0, state}, 16'(CHECK));
    send_gen(1'b0, 1'b0, mx);
    chkb("lock_bit24", locked, 1'b1);
    chkw("state_bit24", {14'b0, state}, 16'(LOCKED));
    for (int i = 25; i <= 1000; i++) send_gen(1'b0, 1'b0, mx);
    chkw("clean_count", err_count, 16'h0000);
    chkb("clean_locked", locked, 1'b1);

    // Single flipped line bit
    guard = 0;
    while (!cand_ok(gen, rxh, 1) && guard < 300) begin
      send_gen(1'b0, 1'b0, mx);
      guard++;
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send_gen(i == 0, 1'b0, mx);
      chkb("flip_pulse", err_pulse, mx);
      if (mx) cnt++;
    end
    chkw("flip_count", err_count, 16'(cnt));
    chkb("flip_locked", locked, 1'b1);

    // Clear alone
    send_gen(1'b0, 1'b1, mx);
    chkw("clr_count", err_count, 16'h0000);
    chkb("clr_locked", locked, 1'b1);

    // Inverted stream until loss of lock
    guard = 0;
    while (!cand_ok(gen, rxh, 16) && guard < 300) begin
      send_gen(1'b0, 1'b0, mx);
      guard++;
    end
    run = 0;
    cnt = 0;
    n   = 0;
    while (run < 8 && n < 40) begin
      send_gen(1'b1, 1'b0, mx);
      n++;
      chkb("inv_pulse", err_pulse, mx);
      if (mx) begin
        run++;
        cnt++;
      end else begin
        run = 0;
      end
      if (run < 8) chkb("inv_locked", locked, 1'b1);
    end
    chkw("inv_count", err_count, 16'(cnt));
    chkb("loss_locked", locked, 1'b0);
    chkw("loss_state", {14'b0, state}, 16'(HUNT));

    // Relock: leading zeros hit the zero guard before the fill starts
    eh = '0;
    x  = gen;
    lz = 0;
    while (gen_next(x) == 1'b0 && lz < 8) begin
      x = {x[7:1], 1'b0};
      lz++;
    end
    for (int i = 0; i < lz + 23; i++) send_gen(1'b0, 1'b0, mx);
    chkb("relock_pre", locked, 1'b0);
    chkw("relock_pre_st", {14'b0, state}, 16'(CHECK));
    send_gen(1'b0, 1'b0, mx);
    chkb("relock", locked, 1'b1);

    // All-zero stream never leaves HUNT
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chkb("zero_locked", locked, 1'b0);
      chkw("zero_state", {14'b0, state}, 16'(HUNT));
    end
    chkw("zero_count", err_count, 16'h0000);

    // 30% valid duty: lock point still at valid bit 24
    do_reset();
    nvalid = 0;
    n      = 0;
    while (nvalid < 40 && n < 3000) begin
      n++;
      if ($urandom_range(0, 99) < 30) begin
        send_gen(1'b0, 1'b0, mx);
        nvalid++;
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chkb("gap_pulse", err_pulse, 1'b0);
      end
      chkb("gap_locked", locked, nvalid >= 24);
    end
    chkb("gap_bound", nvalid >= 40, 1'b1);

    // Clear coinciding with a counted mismatch
    guard = 0;
    while (!cand_ok(gen, rxh, 1) && guard < 300) begin
      send_gen(1'b0, 1'b0, mx);
      guard++;
    end
    send_gen(1'b1, 1'b1, mx);
    chkw("clr_win", err_count, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      send_gen(1'b0, 1'b0, mx);
      chkb("after_clr_pulse", err_pulse, mx);
      if (mx) cnt++;
    end
    chkw("after_clr_count", err_count, 16'(cnt));

    // Saturation: drive chosen mismatch patterns, never 8 in a row
    do_reset();
    for (int i = 0; i < 24; i++) send_gen(1'b0, 1'b0, mx);
    chkb("sat_lock", locked, 1'b1);
    cnt = 0;
    run = 0;
    n   = 0;
    while (cnt < 65540 && n < 90000) begin
      p = rxh[8] ^ rxh[6] ^ rxh[3] ^ rxh[1];
      if (run == 7) m = 1'b0;
      else if (rxh[4:1] == '0) m = ~p;
      else m = 1'b1;
      step(p ^ m, 1'b1, 1'b0);
      n++;
      if (m) begin
        cnt++;
        run++;
      end else begin
        run = 0;
      end
      if (n % 8192 == 0) chkb("sat_pulse", err_pulse, m);
      if (m && cnt == 65534)
        chkw("sat_fffe", err_count, 16'hFFFE);
      if (m && cnt == 65535)
        chkw("sat_ffff", err_count, 16'hFFFF);
    end
    chkw("sat_hold", err_count, 16'hFFFF);
    chkb("sat_locked", locked, 1'b1);

    // Asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chkb("arst_locked", locked, 1'b0);
    chkb("arst_pulse", err_pulse, 1'b0);
    chkw("arst_count", err_count, 16'h0000);
    chkw("arst_state", {14'b0, state}, 16'(HUNT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
